halt_unit: RTL and testbench
============================

HALT_UNIT -- requirements
Module: halt_unit

Interface
REQ-001 Parameter RET_REG, default 1: index of the architectural register whose value is reported as the program return value.
REQ-002 Parameter DRAIN_CYCLES, default 3: number of quiet cycles required between halt retirement and halt assertion.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wb_valid  input  1  an instruction retires from writeback this cycle.
REQ-006 wb_is_halt  input  1  the retiring instruction is a halt; meaningful only when wb_valid=1.
REQ-007 wb_we  input  1  the retiring instruction writes the register file.
REQ-008 wb_dest  input  5  destination register index of the retiring instruction.
REQ-009 wb_data  input  32  value written by the retiring instruction.
REQ-010 mem_busy  input  1  a store or memory transaction is still outstanding.
REQ-011 isHalt  output  1  program has halted and drained; feeds the cycle counter/harness.
REQ-012 ret_val  output  32  shadow copy of register RET_REG; feeds the cycle counter/harness.
REQ-013 retired_count  output  32  number of instructions retired.
REQ-014 halt_pending  output  1  high while in the DRAIN state.

Function
REQ-015 The block SHALL implement a state machine with the states RUN, DRAIN and HALTED.
REQ-016 Shadow update: in RUN, when wb_valid=1, wb_we=1, wb_is_halt=0, wb_dest=RET_REG and wb_dest!=0, ret_val SHALL take wb_data at the next edge.
REQ-017 Writes to register 0 SHALL never update ret_val, and ret_val SHALL stay 0 when RET_REG=0.
REQ-018 Write from halt instruction: a write carried by the halt instruction itself (wb_is_halt=1) SHALL be ignored.
REQ-019 Retire count: in RUN, retired_count SHALL increment by 1 on each edge with wb_valid=1, including the halt instruction.
REQ-020 retired_count SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-021 RUN to DRAIN: in RUN, wb_valid=1 with wb_is_halt=1 SHALL move the state to DRAIN and load the drain counter with DRAIN_CYCLES.
REQ-022 In DRAIN with mem_busy=0: if the counter is 0, the state SHALL move to HALTED; otherwise the counter SHALL decrement.
REQ-023 In DRAIN with mem_busy=1, the counter and state SHALL hold.
REQ-024 Latency: with mem_busy=0 throughout, isHalt SHALL rise exactly DRAIN_CYCLES+1 edges after the edge that samples the halt retire; each DRAIN cycle with mem_busy=1 adds one edge.
REQ-025 DRAIN_CYCLES=0 SHALL give HALTED on the edge after the halt is sampled, given mem_busy=0.
REQ-026 In DRAIN and HALTED, wb_valid SHALL be ignored: no shadow update, no count increment, and no re-entry into DRAIN.
REQ-027 ret_val and retired_count SHALL be frozen from entry into DRAIN onward.
REQ-028 isHalt SHALL be 1 only in HALTED and SHALL be sticky until reset.
REQ-029 halt_pending SHALL be 1 only in DRAIN.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-031 The drain counter SHALL be wide enough for DRAIN_CYCLES and SHALL never underflow.

Reset
REQ-032 While rst=1 at an edge, the state SHALL become RUN, and isHalt, halt_pending, ret_val, retired_count and the drain counter SHALL all become 0.
REQ-033 rst SHALL take priority over every other input, including a halt retiring in the same cycle.
REQ-034 rst in DRAIN or HALTED SHALL abort or clear the halt, and normal RUN behaviour SHALL resume on the following edge.
REQ-035 After reset, no output SHALL change until the first post-reset retire.

Verification
REQ-036 Scenario: retire a write of r1=42, then a halt; DRAIN_CYCLES=3; mem_busy=0 -> isHalt rises 4 edges after the halt edge, ret_val=42, retired_count=2.
REQ-037 Scenario: halt whose own fields are wb_we=1, dest=1, data=99, preceded by r1=7 -> ret_val=7.
REQ-038 Scenario: halt followed by mem_busy=1 for 5 cycles, then 0 -> isHalt rises 9 edges after the halt edge; halt_pending=1 throughout the wait.
REQ-039 Scenario: write r1=5 retiring 1 cycle after the halt (in DRAIN) -> ignored; ret_val unchanged; retired_count unchanged.
REQ-040 Scenario: rst=1 pulsed during DRAIN, then a write r1=3 and a halt -> all outputs 0 after reset; final ret_val=3 and retired_count=2.
REQ-041 Scenario: writes to r0 and r2 with data=0xFFFF_FFFF, then a halt, with RET_REG=1 -> ret_val=0; DRAIN_CYCLES=0 gives isHalt 1 edge after the halt edge.

Source files
------------

// File: rtl/halt_unit_if.sv
// Writeback retire bus and memory-drain status seen by the halt unit.
// The core drives it (master); the halt unit samples it (slave).
interface halt_unit_if;
    logic        wb_valid;
    logic        wb_is_halt;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        mem_busy;

    modport master (
        output wb_valid, wb_is_halt, wb_we,
        output wb_dest, wb_data, mem_busy
    );

    modport slave (
        input wb_valid, wb_is_halt, wb_we,
        input wb_dest, wb_data, mem_busy
    );
endinterface

// File: rtl/halt_unit.sv
// Halt detection: waits for memory to drain after a halt retires,
// then raises a sticky isHalt alongside the shadowed return value.
module halt_unit #(
    parameter int RET_REG      = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    halt_unit_if.slave  wb,
    output logic        isHalt,
    output logic [31:0] ret_val,
    output logic [31:0] retired_count,
    output logic        halt_pending
);

    localparam int CW =
        (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES);
    localparam logic [4:0] RET_IDX = 5'(RET_REG);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [31:0]   ret_nx;
    logic [31:0]   count_nx;
    logic          shadow_hit;

    // r0 is hardwired zero, so a RET_REG of 0 never shadows anything
    assign shadow_hit = wb.wb_we
                      && (wb.wb_dest == RET_IDX)
                      && (wb.wb_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            cnt           <= '0;
            ret_val       <= '0;
            retired_count <= '0;
            isHalt        <= 1'b0;
            halt_pending  <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            ret_val       <= ret_nx;
            retired_count <= count_nx;
            isHalt        <= (state_nx == HALTED);
            halt_pending  <= (state_nx == DRAIN);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ret_nx   = ret_val;
        count_nx = retired_count;
        unique case (state)
            RUN: begin
                if (wb.wb_valid) begin
                    if (retired_count != '1)
                        count_nx = retired_count + 32'd1;
                    if (wb.wb_is_halt) begin
                        state_nx = DRAIN;
                        cnt_nx   = CNT_LOAD;
                    end else if (shadow_hit) begin
                        ret_nx = wb.wb_data;
                    end
                end
            end
            DRAIN: begin
                // an outstanding memory op stalls the drain countdown
                if (!wb.mem_busy) begin
                    if (cnt == '0)
                        state_nx = HALTED;
                    else
                        cnt_nx = cnt - CW'(1);
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_halt_unit.sv
// Bench for halt_unit: vector table, directed corner cases and
// random retire traffic checked against a behavioural model.
module tb_halt_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    halt_unit_if bus ();

    logic        ih [3];
    logic        hp [3];
    logic [31:0] rv [3];
    logic [31:0] rc [3];

    int RR [3] = '{1, 1, 0};
    int DC [3] = '{3, 0, 2};

    halt_unit #(.RET_REG(1), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .wb(bus.slave),
        .isHalt(ih[0]), .ret_val(rv[0]),
        .retired_count(rc[0]), .halt_pending(hp[0])
    );

    halt_unit #(.RET_REG(1), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wb(bus.slave),
        .isHalt(ih[1]), .ret_val(rv[1]),
        .retired_count(rc[1]), .halt_pending(hp[1])
    );

    halt_unit #(.RET_REG(0), .DRAIN_CYCLES(2)) dutr (
        .clk(clk), .rst(rst), .wb(bus.slave),
        .isHalt(ih[2]), .ret_val(rv[2]),
        .retired_count(rc[2]), .halt_pending(hp[2])
    );

    int checks = 0;
    int errors = 0;

    // model: 0=run 1=drain 2=halted; quiet = idle edges still needed
    int          m_mode  [3];
    int          m_quiet [3];
    logic [31:0] m_ret   [3];
    logic [31:0] m_cnt   [3];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_mode[i]  = 0;
                m_quiet[i] = 0;
                m_ret[i]   = 0;
                m_cnt[i]   = 0;
            end else if (m_mode[i] == 0) begin
                if (bus.wb_valid) begin
                    if (m_cnt[i] != 32'hFFFF_FFFF)
                        m_cnt[i] = m_cnt[i] + 1;
                    if (bus.wb_is_halt) begin
                        m_mode[i]  = 1;
                        m_quiet[i] = DC[i] + 1;
                    end else if (bus.wb_we && RR[i] != 0
                                 && int'(bus.wb_dest) == RR[i]) begin
                        m_ret[i] = bus.wb_data;
                    end
                end
            end else if (m_mode[i] == 1) begin
                if (!bus.mem_busy) begin
                    m_quiet[i] = m_quiet[i] - 1;
                    if (m_quiet[i] == 0)
                        m_mode[i] = 2;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("m%0d_isHalt", i),
                32'(ih[i]), 32'(m_mode[i] == 2));
            chk($sformatf("m%0d_pending", i),
                32'(hp[i]), 32'(m_mode[i] == 1));
            chk($sformatf("m%0d_ret", i), rv[i], m_ret[i]);
            chk($sformatf("m%0d_count", i), rc[i], m_cnt[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    task automatic drive(logic r, logic v, logic h, logic we,
                         logic [4:0] d, logic [31:0] x, logic b);
        rst            = r;
        bus.wb_valid   = v;
        bus.wb_is_halt = h;
        bus.wb_we      = we;
        bus.wb_dest    = d;
        bus.wb_data    = x;
        bus.mem_busy   = b;
    endtask

    typedef struct {
        logic        r, v, h, we;
        logic [4:0]  d;
        logic [31:0] x;
        logic        b;
        logic        e_ih, e_hp;
        logic [31:0] e_rv, e_rc;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic h, logic we,
                                logic [4:0] d, logic [31:0] x,
                                logic b, logic e_ih, logic e_hp,
                                logic [31:0] e_rv, logic [31:0] e_rc);
        vec_t t;
        t.r = r; t.v = v; t.h = h; t.we = we;
        t.d = d; t.x = x; t.b = b;
        t.e_ih = e_ih; t.e_hp = e_hp;
        t.e_rv = e_rv; t.e_rc = e_rc;
        return t;
    endfunction

    vec_t tbl [17];
    int   n;
    logic seen_drop;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0);
        tbl[2]  = mk(0, 1, 0, 1, 1, 42, 0, 0, 0, 42, 1);
        tbl[3]  = mk(0, 1, 1, 1, 1, 99, 0, 0, 1, 42, 2);
        tbl[4]  = mk(0, 1, 0, 1, 1, 5,  0, 0, 1, 42, 2);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 42, 2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 42, 2);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 42, 2);
        tbl[8]  = mk(0, 1, 1, 0, 0, 0,  0, 1, 0, 42, 2);
        tbl[9]  = mk(1, 1, 1, 1, 1, 77, 0, 0, 0, 0,  0);
        tbl[10] = mk(0, 1, 0, 1, 1, 7,  0, 0, 0, 7,  1);
        tbl[11] = mk(0, 1, 1, 1, 1, 99, 0, 0, 1, 7,  2);
        tbl[12] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0);
        tbl[13] = mk(0, 1, 0, 1, 1, 3,  0, 0, 0, 3,  1);
        tbl[14] = mk(0, 1, 1, 0, 0, 0,  1, 0, 1, 3,  2);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 3,  2);
        tbl[16] = mk(0, 1, 0, 1, 2, 8,  0, 0, 1, 3,  2);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].h, tbl[i].we,
                  tbl[i].d, tbl[i].x, tbl[i].b);
            step();
            chk($sformatf("t%0d_isHalt", i),
                32'(ih[0]), 32'(tbl[i].e_ih));
            chk($sformatf("t%0d_pending", i),
                32'(hp[0]), 32'(tbl[i].e_hp));
            chk($sformatf("t%0d_ret", i), rv[0], tbl[i].e_rv);
            chk($sformatf("t%0d_count", i), rc[0], tbl[i].e_rc);
        end

        // halt then 5 busy cycles: 9 edges to isHalt, pending throughout
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 1, 0, 0, 0, 0);
        step();
        n = 0;
        seen_drop = 1'b0;
        while (n < 40 && !ih[0]) begin
            drive(0, 0, 0, 0, 0, 0, (n < 5) ? 1'b1 : 1'b0);
            step();
            n++;
            if (!ih[0] && !hp[0])
                seen_drop = 1'b1;
        end
        chk("busy_latency", 32'(n), 32'd9);
        chk("busy_pending_held", 32'(seen_drop), 32'd0);

        // r0 and r2 writes never reach the shadow; zero-cycle drain
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0);
        step();
        drive(0, 1, 0, 1, 2, 32'hFFFF_FFFF, 0);
        step();
        drive(0, 1, 1, 0, 0, 0, 0);
        step();
        chk("r0r2_ret", rv[1], 32'd0);
        chk("drain0_pending", 32'(hp[1]), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("drain0_isHalt", 32'(ih[1]), 32'd1);
        chk("drain0_count", rc[1], 32'd3);

        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 79) == 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 11) == 0),
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)),
                  $urandom,
                  ($urandom_range(0, 2) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
